// File: rtl/frame_timing_ctrl_if.sv
// Control/status bundle of the frame timing sequencer.
// master = the controller driving launch/stop/abort, slave = the sequencer.
interface frame_timing_ctrl_if #(
  parameter int unsigned AW = 21
);
  logic          start;
  logic          cont;
  logic          stop;
  logic          abort;
  logic          busy;
  logic          vvalid;
  logic          hvalid;
  logic [AW-1:0] addr;
  logic          sof;
  logic          eol;
  logic          eof;
  logic [15:0]   line_cnt;
  logic [15:0]   frame_cnt;

  modport master (
    output start, cont, stop, abort,
    input  busy, vvalid, hvalid, addr, sof, eol, eof, line_cnt, frame_cnt
  );

  modport slave (
    input  start, cont, stop, abort,
    output busy, vvalid, hvalid, addr, sof, eol, eof, line_cnt, frame_cnt
  );
endinterface

// File: rtl/frame_timing_ctrl.sv
// Programmable video-timing sequencer: frame/line qualifiers, linear pixel
// address and sof/eol/eof markers, with one-shot, continuous and abort control.
module frame_timing_ctrl #(
  parameter int unsigned H_ACT   = 1920,
  parameter int unsigned H_BLANK = 128,
  parameter int unsigned V_ACT   = 1080,
  parameter int unsigned V_FRONT = 64,
  parameter int unsigned V_BACK  = 64,
  parameter int unsigned AW      = 21
) (
  input  logic                clk,
  input  logic                rst,
  frame_timing_ctrl_if.slave  bus
);

  localparam int unsigned PM1  = (H_ACT > H_BLANK) ? H_ACT : H_BLANK;
  localparam int unsigned PM2  = (PM1 > V_FRONT) ? PM1 : V_FRONT;
  localparam int unsigned PMAX = (PM2 > V_BACK) ? PM2 : V_BACK;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VFRONT,
    HBLANK,
    HACT,
    VBACK
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     line_q, line_d;
  logic [15:0]     frame_q, frame_d;
  logic            stop_pend_q, stop_pend_d;
  logic            busy_q, busy_d;
  logic            vvalid_q, vvalid_d;
  logic            hvalid_q, hvalid_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            eof_q, eof_d;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q + PW'(1);
    addr_d      = addr_q;
    line_d      = line_q;
    frame_d     = frame_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (bus.start) begin
          state_d = VFRONT;
          addr_d  = '0;
          line_d  = '0;
        end
      end
      VFRONT: begin
        if (ph_q == PW'(V_FRONT - 1)) begin
          state_d = HBLANK;
          ph_d    = '0;
        end
      end
      HBLANK: begin
        if (ph_q == PW'(H_BLANK - 1)) begin
          state_d = HACT;
          ph_d    = '0;
          // addr holds the previous line's last pixel; line 0 already starts at 0
          if (line_q != '0) addr_d = addr_q + AW'(1);
        end
      end
      HACT: begin
        if (ph_q == PW'(H_ACT - 1)) begin
          ph_d = '0;
          if (line_q == 16'(V_ACT - 1)) begin
            state_d = VBACK;
          end else begin
            state_d = HBLANK;
            line_d  = line_q + 16'd1;
          end
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      VBACK: begin
        if (ph_q == PW'(V_BACK - 1)) begin
          ph_d    = '0;
          frame_d = frame_q + 16'd1;
          // a stop arriving on the very last cycle still ends the sequence
          if (bus.cont && !stop_pend_q && !bus.stop) begin
            state_d = VFRONT;
            addr_d  = '0;
            line_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      addr_d  = addr_q;
      line_d  = line_q;
      frame_d = frame_q;
    end

    if (state_d == IDLE)
      stop_pend_d = 1'b0;
    else if (bus.stop && state_q != IDLE)
      stop_pend_d = 1'b1;

    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != IDLE);
    vvalid_d = (state_d == HBLANK) || (state_d == HACT);
    hvalid_d = (state_d == HACT);
    sof_d    = (state_d == HACT) && (state_q == HBLANK) && (line_q == '0);
    eol_d    = (state_d == HACT) && (ph_d == PW'(H_ACT - 1));
    eof_d    = (state_d == VBACK) && (ph_d == PW'(V_BACK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      frame_q     <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      vvalid_q    <= 1'b0;
      hvalid_q    <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      vvalid_q    <= vvalid_d;
      hvalid_q    <= hvalid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.vvalid    = vvalid_q;
  assign bus.hvalid    = hvalid_q;
  assign bus.addr      = addr_q;
  assign bus.sof       = sof_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.line_cnt  = line_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Bench for frame_timing_ctrl: scenario table, async reset sequence and random
// control stimulus, all checked cycle-by-cycle against a frame-position model.
module tb_frame_timing_ctrl;

  localparam int HA  = 4;
  localparam int HB  = 2;
  localparam int VA  = 3;
  localparam int VF  = 3;
  localparam int VB  = 2;
  localparam int AWT = 8;
  localparam int LL  = HA + HB;
  localparam int FL  = VF + VA * LL + VB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_timing_ctrl_if #(.AW(AWT)) bus ();

  frame_timing_ctrl #(
    .H_ACT  (HA),
    .H_BLANK(HB),
    .V_ACT  (VA),
    .V_FRONT(VF),
    .V_BACK (VB),
    .AW     (AWT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position counter plus held address/line values.
  logic            m_busy, m_stop;
  int              m_pos;
  logic [AWT-1:0]  m_addr;
  logic [15:0]     m_line, m_frame;
  logic            e_vv, e_hv, e_sof, e_eol, e_eof;

  task automatic model_reset();
    m_busy = 0; m_stop = 0; m_pos = 0; m_addr = '0; m_line = '0; m_frame = '0;
    e_vv = 0; e_hv = 0; e_sof = 0; e_eol = 0; e_eof = 0;
  endtask

  task automatic model_step(input logic s, input logic c, input logic st, input logic ab);
    int q, ln, col;
    if (ab) begin
      m_busy = 0; m_stop = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_pos = 0; m_addr = '0; m_line = '0;
      end
    end else begin
      if (st) m_stop = 1;
      if (m_pos == FL - 1) begin
        m_frame = m_frame + 16'd1;
        if (c && !m_stop) begin
          m_pos = 0; m_addr = '0; m_line = '0;
        end else begin
          m_busy = 0; m_stop = 0;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
    e_vv = 0; e_hv = 0; e_sof = 0; e_eol = 0; e_eof = 0;
    if (m_busy) begin
      if (m_pos >= VF && m_pos < VF + VA * LL) begin
        q = m_pos - VF; ln = q / LL; col = q % LL;
        e_vv = 1;
        m_line = 16'(ln);
        if (col >= HB) begin
          e_hv   = 1;
          m_addr = AWT'(ln * HA + col - HB);
          e_sof  = (m_addr == '0);
          e_eol  = (col == LL - 1);
        end
      end else if (m_pos >= VF + VA * LL) begin
        m_line = 16'(VA - 1);
      end
      e_eof = (m_pos == FL - 1);
    end
  endtask

  function automatic logic [45:0] dut_vec();
    return {bus.busy, bus.vvalid, bus.hvalid, bus.sof, bus.eol, bus.eof,
            bus.addr, bus.line_cnt, bus.frame_cnt};
  endfunction

  function automatic logic [45:0] exp_vec();
    return {m_busy, e_vv, e_hv, e_sof, e_eol, e_eof, m_addr, m_line, m_frame};
  endfunction

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start = 0; bus.cont = 0; bus.stop = 0; bus.abort = 0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic step(input logic s, input logic c, input logic st, input logic ab, input int k);
    bus.start = s; bus.cont = c; bus.stop = st; bus.abort = ab;
    @(posedge clk);
    model_step(s, c, st, ab);
    #1;
    check("cycle", k, 64'(dut_vec()), 64'(exp_vec()));
  endtask

  typedef struct {
    string name;
    logic  cont;
    int    s0, s1, s2;
    int    stop_at, abort_at;
    int    ncyc;
    int    frames, eofs, sofs;
    int    drop, first_sof, first_eof;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int eofs, sofs, drop, fsof, feof;
    logic prev_busy;

    tbl[0] = '{"oneshot",    1'b0, 0, -1, -1, -1, -1, 30, 1, 1, 1, 23, 5, 22};
    tbl[1] = '{"cont3",      1'b1, 0, -1, -1, -1, -1, 70, 3, 3, 3, -1, 5, 22};
    tbl[2] = '{"cont_stop",  1'b1, 0, -1, -1, 30, -1, 60, 2, 2, 2, 46, 5, 22};
    tbl[3] = '{"abort",      1'b0, 0, 15, -1, -1, 12, 45, 1, 1, 2, 12, 5, 37};
    tbl[4] = '{"ign_start",  1'b0, 0, 1, 10, -1, 0,  30, 1, 1, 1, 24, 6, 23};

    reset_dut();
    check("reset_state", 0, 64'(dut_vec()), 64'd0);

    foreach (tbl[i]) begin
      reset_dut();
      eofs = 0; sofs = 0; drop = -1; fsof = -1; feof = -1; prev_busy = 0;
      for (int k = 0; k < tbl[i].ncyc; k++) begin
        step(k == tbl[i].s0 || k == tbl[i].s1 || k == tbl[i].s2, tbl[i].cont,
             k == tbl[i].stop_at, k == tbl[i].abort_at, k);
        if (bus.eof) begin eofs++; if (feof < 0) feof = k; end
        if (bus.sof) begin sofs++; if (fsof < 0) fsof = k; end
        if (prev_busy && !bus.busy && drop < 0) drop = k;
        prev_busy = bus.busy;
      end
      check({tbl[i].name, "_frames"}, tbl[i].ncyc, 64'(bus.frame_cnt), 64'(tbl[i].frames));
      check({tbl[i].name, "_eofs"},   tbl[i].ncyc, 64'(eofs), 64'(tbl[i].eofs));
      check({tbl[i].name, "_sofs"},   tbl[i].ncyc, 64'(sofs), 64'(tbl[i].sofs));
      check({tbl[i].name, "_drop"},   tbl[i].ncyc, 64'(drop), 64'(tbl[i].drop));
      check({tbl[i].name, "_sof_at"}, tbl[i].ncyc, 64'(fsof), 64'(tbl[i].first_sof));
      check({tbl[i].name, "_eof_at"}, tbl[i].ncyc, 64'(feof), 64'(tbl[i].first_eof));
    end

    // Asynchronous reset in the middle of the first active line.
    reset_dut();
    for (int k = 0; k <= 6; k++) step(k == 0, 1'b0, 1'b0, 1'b0, k);
    check("pre_rst_hvalid", 6, 64'(bus.hvalid), 64'd1);
    #2 rst = 1;
    #1 check("async_rst", 6, 64'(dut_vec()), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, k);
    for (int k = 0; k < 26; k++) step(k == 0, 1'b0, 1'b0, 1'b0, k);
    check("post_rst_frames", 26, 64'(bus.frame_cnt), 64'd1);

    // Random control traffic against the model.
    reset_dut();
    begin
      logic c;
      c = 1'b1;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 79) == 0) c = ~c;
        step($urandom_range(0, 5) == 0, c, $urandom_range(0, 49) == 0,
             $urandom_range(0, 89) == 0, k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
